fe_uop_queue: RTL and testbench

Decoupling FIFO between the frontend decode stage and the out-of-order engine's rename stage. Captures each decoded micro-op bundle (uop, register specifiers, immediate, PC, exception vector, predictor BHRs) and releases it to rename under a valid/ready handshake. Throttles the frontend with an early stall so in-flight frontend stages can drain into skid slots. Flushes completely on any resteer.

---
 rtl/fe_uop_queue.sv | 180 ++++++++++++++++++
 tb/tb_fe_uop_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fe_uop_queue.sv
// fe_uop_queue: decoupling FIFO between frontend decode and rename.
// Holds whole decoded uop bundles and releases them under valid/ready. It
// raises an early stall so that uops already in the frontend pipe can still
// land in the reserved skid slots. Any resteer (flush) empties the queue.
module fe_uop_queue #(
   parameter int DEPTH = 8,
   parameter int SKID  = 2,
   parameter int UOP_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       valid_in,
   input  logic [UOP_W-1:0]           uop_in,
   input  logic                       eoi_in,
   input  logic [4:0]                 dr_in,
   input  logic [4:0]                 sr1_in,
   input  logic [4:0]                 sr2_in,
   input  logic [31:0]                imm_in,
   input  logic                       use_imm_in,
   input  logic [31:0]                pc_in,
   input  logic                       exception_in,
   input  logic [9:0]                 pcbp_bhr_in,
   input  logic [9:0]                 clbp_bhr_in,
   output logic                       stall_out,
   output logic                       valid_out,
   input  logic                       ready_in,
   output logic [UOP_W-1:0]           uop_out,
   output logic                       eoi_out,
   output logic [4:0]                 dr_out,
   output logic [4:0]                 sr1_out,
   output logic [4:0]                 sr2_out,
   output logic [31:0]                imm_out,
   output logic                       use_imm_out,
   output logic [31:0]                pc_out,
   output logic                       exception_out,
   output logic [9:0]                 pcbp_bhr_out,
   output logic [9:0]                 clbp_bhr_out,
   output logic                       inst_avail,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // One stored bundle: UOP_W + 102 bits.
   typedef struct packed {
      logic [UOP_W-1:0] uop;
      logic             eoi;
      logic [4:0]       dr;
      logic [4:0]       sr1;
      logic [4:0]       sr2;
      logic [31:0]      imm;
      logic             use_imm;
      logic [31:0]      pc;
      logic             exception;
      logic [9:0]       pcbp_bhr;
      logic [9:0]       clbp_bhr;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          wr_entry;
   entry_t          head_entry;

   logic [AW-1:0]   head_reg;
   logic [AW-1:0]   tail_reg;
   logic [CW-1:0]   count_reg;
   logic [CW-1:0]   count_next;
   logic [CW-1:0]   eoi_cnt_reg;
   logic [CW-1:0]   eoi_cnt_next;
   logic            overflow_reg;

   logic            full;
   logic            enq;
   logic            deq;
   logic            drop;
   logic            eoi_inc;
   logic            eoi_dec;

   // Handshake decode. A full queue still accepts when the head leaves in
   // the same cycle, so sustained one-in/one-out never drops.
   always_comb begin
      full    = (count_reg == CW'(DEPTH));
      deq     = (count_reg != '0) && ready_in && !flush;
      enq     = valid_in && !flush && (!full || deq);
      drop    = valid_in && !flush && full && !deq;
      eoi_inc = enq && eoi_in;
      eoi_dec = deq && head_entry.eoi;
   end

   // Next occupancy and eoi population; both unchanged when in and out cancel.
   always_comb begin
      count_next   = count_reg;
      eoi_cnt_next = eoi_cnt_reg;
      case ({enq, deq})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
      case ({eoi_inc, eoi_dec})
         2'b10:   eoi_cnt_next = eoi_cnt_reg + CW'(1);
         2'b01:   eoi_cnt_next = eoi_cnt_reg - CW'(1);
         default: eoi_cnt_next = eoi_cnt_reg;
      endcase
   end

   // Pack the incoming bundle for storage.
   always_comb begin
      wr_entry.uop       = uop_in;
      wr_entry.eoi       = eoi_in;
      wr_entry.dr        = dr_in;
      wr_entry.sr1       = sr1_in;
      wr_entry.sr2       = sr2_in;
      wr_entry.imm       = imm_in;
      wr_entry.use_imm   = use_imm_in;
      wr_entry.pc        = pc_in;
      wr_entry.exception = exception_in;
      wr_entry.pcbp_bhr  = pcbp_bhr_in;
      wr_entry.clbp_bhr  = clbp_bhr_in;
   end

   // Entry storage; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (enq) begin
         mem[tail_reg] <= wr_entry;
      end
   end

   // Control state: pointers, occupancy, eoi population, sticky overflow.
   // Flush clears everything except overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_reg     <= '0;
         tail_reg     <= '0;
         count_reg    <= '0;
         eoi_cnt_reg  <= '0;
         overflow_reg <= 1'b0;
      end else if (flush) begin
         head_reg     <= '0;
         tail_reg     <= '0;
         count_reg    <= '0;
         eoi_cnt_reg  <= '0;
      end else begin
         if (enq) begin
            tail_reg <= tail_reg + AW'(1);
         end
         if (deq) begin
            head_reg <= head_reg + AW'(1);
         end
         count_reg   <= count_next;
         eoi_cnt_reg <= eoi_cnt_next;
         if (drop) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   // Head read and status outputs; all from registered state, never ready_in.
   always_comb begin
      head_entry    = mem[head_reg];
      valid_out     = (count_reg != '0);
      stall_out     = (count_reg >= CW'(DEPTH - SKID));
      inst_avail    = (eoi_cnt_reg != '0);
      count         = count_reg;
      overflow      = overflow_reg;
      uop_out       = head_entry.uop;
      eoi_out       = head_entry.eoi;
      dr_out        = head_entry.dr;
      sr1_out       = head_entry.sr1;
      sr2_out       = head_entry.sr2;
      imm_out       = head_entry.imm;
      use_imm_out   = head_entry.use_imm;
      pc_out        = head_entry.pc;
      exception_out = head_entry.exception;
      pcbp_bhr_out  = head_entry.pcbp_bhr;
      clbp_bhr_out  = head_entry.clbp_bhr;
   end

endmodule

// File: tb/tb_fe_uop_queue.sv
// tb_fe_uop_queue: directed checks of fe_uop_queue (DEPTH=8, SKID=2).
module tb_fe_uop_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        valid_in;
   logic [7:0]  uop_in;
   logic        eoi_in;
   logic [4:0]  dr_in, sr1_in, sr2_in;
   logic [31:0] imm_in;
   logic        use_imm_in;
   logic [31:0] pc_in;
   logic        exception_in;
   logic [9:0]  pcbp_bhr_in, clbp_bhr_in;
   logic        stall_out;
   logic        valid_out;
   logic        ready_in;
   logic [7:0]  uop_out;
   logic        eoi_out;
   logic [4:0]  dr_out, sr1_out, sr2_out;
   logic [31:0] imm_out;
   logic        use_imm_out;
   logic [31:0] pc_out;
   logic        exception_out;
   logic [9:0]  pcbp_bhr_out, clbp_bhr_out;
   logic        inst_avail;
   logic [3:0]  count;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   fe_uop_queue #(.DEPTH(8), .SKID(2), .UOP_W(8)) dut (
      .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in),
      .uop_in(uop_in), .eoi_in(eoi_in), .dr_in(dr_in), .sr1_in(sr1_in),
      .sr2_in(sr2_in), .imm_in(imm_in), .use_imm_in(use_imm_in),
      .pc_in(pc_in), .exception_in(exception_in),
      .pcbp_bhr_in(pcbp_bhr_in), .clbp_bhr_in(clbp_bhr_in),
      .stall_out(stall_out), .valid_out(valid_out), .ready_in(ready_in),
      .uop_out(uop_out), .eoi_out(eoi_out), .dr_out(dr_out),
      .sr1_out(sr1_out), .sr2_out(sr2_out), .imm_out(imm_out),
      .use_imm_out(use_imm_out), .pc_out(pc_out),
      .exception_out(exception_out), .pcbp_bhr_out(pcbp_bhr_out),
      .clbp_bhr_out(clbp_bhr_out), .inst_avail(inst_avail),
      .count(count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check, reports mismatches.
   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, obs);
      end
   endtask

   // Advance one clock; sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a uop; fields derived from the PC so they are distinguishable.
   task automatic put(input logic [31:0] pc, input logic eoi);
      valid_in     = 1'b1;
      pc_in        = pc;
      eoi_in       = eoi;
      uop_in       = pc[7:0];
      dr_in        = pc[6:2];
      sr1_in       = pc[7:3];
      sr2_in       = pc[8:4];
      imm_in       = ~pc;
      use_imm_in   = pc[2];
      exception_in = pc[3];
      pcbp_bhr_in  = pc[9:0];
      clbp_bhr_in  = ~pc[9:0];
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; ready_in = 1'b0;
      put(32'h0, 1'b0);
      valid_in = 1'b0;

      // Reset state
      #12;
      check("rst_valid", valid_out, 0);
      check("rst_stall", stall_out, 0);
      check("rst_inst_avail", inst_avail, 0);
      check("rst_count", count, 0);
      check("rst_overflow", overflow, 0);
      #2 rst = 1'b1;
      tick();

      // Basic order plus eoi tracking (eoi = 0,0,1)
      put(32'h100, 1'b0); tick();
      check("b1_count", count, 1);
      check("b1_valid", valid_out, 1);
      check("b1_avail", inst_avail, 0);
      put(32'h104, 1'b0); tick();
      check("b2_avail", inst_avail, 0);
      put(32'h108, 1'b1); tick();
      check("b3_avail", inst_avail, 1);
      valid_in = 1'b0;
      check("b_count", count, 3);
      check("b_valid", valid_out, 1);
      check("b_pc0", pc_out, 32'h100);
      check("b_imm0", imm_out, ~32'h100);
      ready_in = 1'b1;
      tick();
      check("b_pc1", pc_out, 32'h104);
      check("b_avail1", inst_avail, 1);
      tick();
      check("b_pc2", pc_out, 32'h108);
      check("b_eoi2", eoi_out, 1);
      check("b_avail2", inst_avail, 1);
      tick();
      check("b_valid_end", valid_out, 0);
      check("b_avail_end", inst_avail, 0);
      ready_in = 1'b0;

      // Fill to full, watching the skid stall threshold
      for (int i = 0; i < 8; i++) begin
         put(32'h200 + 4 * i, 1'b0); tick();
         check($sformatf("fill%0d_count", i), count, i + 1);
         check($sformatf("fill%0d_stall", i), stall_out, (i >= 5) ? 1 : 0);
      end
      check("fill_overflow", overflow, 0);

      // Full with simultaneous dequeue: accepted, no overflow
      put(32'h300, 1'b0); ready_in = 1'b1; tick();
      check("fd_count", count, 8);
      check("fd_overflow", overflow, 0);
      check("fd_pc", pc_out, 32'h204);

      // Full without dequeue: dropped, overflow set
      put(32'h999, 1'b0); ready_in = 1'b0; tick();
      check("ov_count", count, 8);
      check("ov_overflow", overflow, 1);

      // Drain: 0x204..0x21c then 0x300; 0x999 never appears
      valid_in = 1'b0; ready_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain%0d_pc", i), pc_out,
               (i < 7) ? 32'h204 + 4 * i : 32'h300);
         tick();
      end
      check("drain_valid", valid_out, 0);
      check("drain_stall", stall_out, 0);

      // Wrap-around streaming, one in one out per cycle
      for (int i = 0; i < 20; i++) begin
         put(32'h400 + 4 * i, 1'b0); tick();
         check($sformatf("wr%0d_count", i), count, 1);
         check($sformatf("wr%0d_pc", i), pc_out, 32'h400 + 4 * i);
      end
      valid_in = 1'b0; tick();
      check("wr_end_valid", valid_out, 0);

      // Flush priority over enqueue and dequeue
      ready_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         put(32'h500 + 4 * i, 1'b1); tick();
      end
      check("fl_count_pre", count, 5);
      check("fl_avail_pre", inst_avail, 1);
      flush = 1'b1; ready_in = 1'b1; put(32'h5f0, 1'b1); tick();
      flush = 1'b0; ready_in = 1'b0;
      check("fl_count", count, 0);
      check("fl_valid", valid_out, 0);
      check("fl_avail", inst_avail, 0);
      check("fl_overflow", overflow, 1);
      put(32'h600, 1'b0); tick();
      valid_in = 1'b0;
      check("fl_after_count", count, 1);
      check("fl_after_pc", pc_out, 32'h600);

      // Asynchronous reset mid-operation
      put(32'h700, 1'b1); tick(); valid_in = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("ar_count", count, 0);
      check("ar_valid", valid_out, 0);
      check("ar_avail", inst_avail, 0);
      check("ar_overflow", overflow, 0);
      #3 rst = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
